mem_wb_slice: RTL

- Memory-access and write-back end of the 5-stage pipeline; consumes the EX/M/WB control bundles produced at decode after they pass through EX.
- Runs the data-memory request/acknowledge handshake and stalls upstream while memory is busy.
- Registers the MEM/WB result and drives the write port of the register file in the decode stage: write data, write enable, destination.
- Redirects the PC on RET.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/mem_wb_slice_if.sv | 14 +
 rtl/mem_wb_slice_mem_wb_reg.sv | 40 ++++
 rtl/mem_wb_slice.sv | 116 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: M-bundle bit positions, memory FSM states and the opcode set.
// The opcode set is also used by the decode stage.
package cpu_pkg;

  localparam int M_SPTOPC   = 2;
  localparam int M_MEMWRITE = 1;
  localparam int M_MEMREAD  = 0;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_LW   = 4'h8,
    OP_SW   = 4'h9,
    OP_CALL = 4'hC,
    OP_RET  = 4'hD
  } opcode_e;

  // Instruction fields held for the duration of a memory access.
  typedef struct packed {
    logic [3:0] rd;
    logic       sp_to_pc;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } mem_ctrl_t;

  function automatic logic is_mem_op(input logic [2:0] m);
    return m[M_MEMREAD] | m[M_MEMWRITE];
  endfunction

endpackage

// File: rtl/mem_wb_slice_if.sv
// Data-memory request/acknowledge handshake between the MEM stage and data memory.
interface mem_wb_slice_if #(
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] wdata;
  logic              ack;
  logic [ADDR_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_wb_slice_mem_wb_reg.sv
// MEM/WB output register: write-back and PC-redirect strobes are single-cycle pulses,
// while data, destination and target hold their last retired values.
module mem_wb_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         retire,
  input  logic [W-1:0] data,
  input  logic [3:0]   dst,
  input  logic         reg_write,
  input  logic         redirect,
  input  logic [W-1:0] target,
  output logic [W-1:0] wb_write_data,
  output logic         wb_RegWrite,
  output logic [3:0]   wb_dst,
  output logic         pc_redirect,
  output logic [W-1:0] pc_target
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_write_data <= '0;
      wb_RegWrite   <= 1'b0;
      wb_dst        <= '0;
      pc_redirect   <= 1'b0;
      pc_target     <= '0;
    end else begin
      wb_RegWrite <= retire & reg_write;
      pc_redirect <= retire & redirect;
      if (retire) begin
        wb_write_data <= data;
        wb_dst        <= dst;
      end
      if (retire && redirect) pc_target <= target;
    end
  end

endmodule

// File: rtl/mem_wb_slice.sv
// Memory-access and write-back end of the pipeline: runs the data-memory handshake,
// stalls upstream while busy, retires results to the register file and redirects on RET.
module mem_wb_slice
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_alu_result,
  input  logic [ADDR_W-1:0] ex_store_data,
  input  logic [ADDR_W-1:0] ex_pc_inc,
  input  logic [3:0]        ex_rd,
  input  logic [2:0]        ex_M,
  input  logic              ex_PCToMem,
  input  logic              ex_MemToReg,
  input  logic              ex_RegWrite,
  output logic              stall_out,
  mem_wb_slice_if.master    dmem,
  output logic [ADDR_W-1:0] wb_write_data,
  output logic              wb_RegWrite,
  output logic [3:0]        wb_dst,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  mem_ctrl_t         ctrl_q;
  logic [ADDR_W-1:0] addr_q, wdata_q;

  logic issue, timeout;
  logic              retire, rt_reg_write, rt_redirect;
  logic [ADDR_W-1:0] rt_data, rt_target;
  logic [3:0]        rt_dst;

  assign issue   = (state_q == IDLE) && ex_valid && is_mem_op(ex_M);
  assign timeout = (state_q == ACCESS) && !dmem.ack && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
      if (issue) begin
        ctrl_q  <= '{rd: ex_rd, sp_to_pc: ex_M[M_SPTOPC], mem_write: ex_M[M_MEMWRITE],
                     mem_to_reg: ex_MemToReg, reg_write: ex_RegWrite};
        addr_q  <= ex_alu_result;
        wdata_q <= ex_PCToMem ? ex_pc_inc : ex_store_data;
      end
      if (timeout) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = ACCESS;
      ACCESS:  if (dmem.ack || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    stall_out    = (state_q == ACCESS) && !dmem.ack;
    dmem.req     = (state_q == ACCESS);
    dmem.we      = (state_q == ACCESS) && ctrl_q.mem_write;
    dmem.addr    = addr_q;
    dmem.wdata   = wdata_q;
    retire       = 1'b0;
    rt_data      = ex_alu_result;
    rt_dst       = ex_rd;
    rt_reg_write = ex_RegWrite;
    rt_redirect  = 1'b0;
    rt_target    = dmem.rdata;
    if (state_q == IDLE) begin
      retire = ex_valid && !is_mem_op(ex_M);
    end else if (dmem.ack) begin
      // A simultaneous read+write is a write, so its read data never reaches the register file.
      retire       = 1'b1;
      rt_data      = (ctrl_q.mem_to_reg && !ctrl_q.mem_write) ? dmem.rdata : addr_q;
      rt_dst       = ctrl_q.rd;
      rt_reg_write = ctrl_q.reg_write;
      rt_redirect  = ctrl_q.sp_to_pc;
    end
  end

  mem_wb_reg #(.W(ADDR_W)) u_mem_wb_reg (
    .clk           (clk),
    .rst           (rst),
    .retire        (retire),
    .data          (rt_data),
    .dst           (rt_dst),
    .reg_write     (rt_reg_write),
    .redirect      (rt_redirect),
    .target        (rt_target),
    .wb_write_data (wb_write_data),
    .wb_RegWrite   (wb_RegWrite),
    .wb_dst        (wb_dst),
    .pc_redirect   (pc_redirect),
    .pc_target     (pc_target)
  );

endmodule
